// File: rtl/booth_mul_pkg.sv
// Shared Booth radix-4 definitions: digit encodings and sizing helpers used by the
// multiplier top and its partial-product generator.
package booth_mul_pkg;

  typedef enum logic [2:0] {
    ZERO = 3'd0,
    POS1 = 3'd1,
    NEG1 = 3'd2,
    POS2 = 3'd3,
    NEG2 = 3'd4
  } booth_digit_e;

  // ceil((b_width+1)/2) radix-4 digits cover a sign-extended multiplier
  function automatic int booth_pp_count(input int b_width);
    return (b_width + 2) / 2;
  endfunction

  function automatic int booth_prod_width(input int a_width, input int b_width);
    return a_width + b_width;
  endfunction

endpackage

// File: rtl/booth_pp_gen.sv
// One Booth radix-4 digit: recodes a multiplier bit triplet and produces the
// matching partial product, sign-extended to PW bits and shifted into place.
module booth_pp_gen
  import booth_mul_pkg::*;
#(
  parameter int AW    = 13,
  parameter int PW    = 26,
  parameter int SHIFT = 0
) (
  input  logic [AW-1:0] a_i,
  input  logic [2:0]    triplet_i,
  output logic [PW-1:0] pp_o
);

  booth_digit_e  digit;
  logic [PW-1:0] a_sx;
  logic [PW-1:0] mag;

  assign a_sx = {{(PW-AW){a_i[AW-1]}}, a_i};

  always_comb begin
    digit = ZERO;
    case (triplet_i)
      3'b001, 3'b010: digit = POS1;
      3'b011:         digit = POS2;
      3'b100:         digit = NEG2;
      3'b101, 3'b110: digit = NEG1;
      default:        digit = ZERO;
    endcase
  end

  always_comb begin
    mag = '0;
    case (digit)
      POS1:    mag = a_sx;
      NEG1:    mag = -a_sx;
      POS2:    mag = a_sx << 1;
      NEG2:    mag = -(a_sx << 1);
      default: mag = '0;
    endcase
  end

  assign pp_o = mag << SHIFT;

endmodule

// File: rtl/booth_pipe_multiplier.sv
// Three-stage radix-4 Booth multiplier with valid/ready flow control.
// Define BOOTH_MUL_UNSIGNED_EN to add TC_MODE (1 = signed, 0 = unsigned operands).
module booth_pipe_multiplier
  import booth_mul_pkg::*;
#(
  parameter int A_WIDTH = 13,
  parameter int B_WIDTH = 13
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [A_WIDTH-1:0]         A_NUM,
  input  logic [B_WIDTH-1:0]         B_NUM,
`ifdef BOOTH_MUL_UNSIGNED_EN
  input  logic                       TC_MODE,
`endif
  input  logic                       IN_VALID,
  output logic                       IN_READY,
  output logic [A_WIDTH+B_WIDTH-1:0] C_NUM,
  output logic                       OUT_VALID,
  input  logic                       OUT_READY
);

`ifdef BOOTH_MUL_UNSIGNED_EN
  localparam int EXT = 1;
`else
  localparam int EXT = 0;
`endif
  localparam int AW  = A_WIDTH + EXT;
  localparam int BW  = B_WIDTH + EXT;
  localparam int NPP = booth_pp_count(BW);
  localparam int PW  = booth_prod_width(AW, BW);
  localparam int CW  = A_WIDTH + B_WIDTH;
  localparam int BE  = 2 * NPP;

  logic               v1_q, v2_q, v3_q;
  logic               v1_d, v2_d, v3_d;
  logic               rdy1, rdy2, rdy3;
  logic [A_WIDTH-1:0] a_q;
  logic [B_WIDTH-1:0] b_q;
  logic [AW-1:0]      a_ext;
  logic [BW-1:0]      b_ext;
  logic [BE:0]        b_pad;
  logic [PW-1:0]      pp_d [NPP];
  logic [PW-1:0]      pp_q [NPP];
  logic [PW-1:0]      sum_d;
  logic [CW-1:0]      c_q;

  // Each stage may load when it is empty or its contents move on this edge
  assign rdy3 = !v3_q || OUT_READY;
  assign rdy2 = !v2_q || rdy3;
  assign rdy1 = !v1_q || rdy2;

  assign v1_d = rdy1 ? IN_VALID : v1_q;
  assign v2_d = rdy2 ? v1_q     : v2_q;
  assign v3_d = rdy3 ? v2_q     : v3_q;

  assign IN_READY  = rdy1;
  assign OUT_VALID = v3_q;
  assign C_NUM     = c_q;

  // S1: operand capture
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      v1_q <= 1'b0;
      a_q  <= '0;
      b_q  <= '0;
    end else begin
      v1_q <= v1_d;
      if (rdy1 && IN_VALID) begin
        a_q <= A_NUM;
        b_q <= B_NUM;
      end
    end
  end

`ifdef BOOTH_MUL_UNSIGNED_EN
  logic tc_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tc_q <= 1'b0;
    end else if (rdy1 && IN_VALID) begin
      tc_q <= TC_MODE;
    end
  end

  // Unsigned operands become non-negative signed values one bit wider
  assign a_ext = {tc_q & a_q[A_WIDTH-1], a_q};
  assign b_ext = {tc_q & b_q[B_WIDTH-1], b_q};
`else
  assign a_ext = a_q;
  assign b_ext = b_q;
`endif

  // S2: Booth recode and partial-product generation; implicit b[-1] = 0
  assign b_pad = {{(BE-BW){b_ext[BW-1]}}, b_ext, 1'b0};

  generate
    for (genvar gi = 0; gi < NPP; gi++) begin : g_pp
      booth_pp_gen #(
        .AW   (AW),
        .PW   (PW),
        .SHIFT(2 * gi)
      ) u_pp_gen (
        .a_i      (a_ext),
        .triplet_i(b_pad[2*gi+2 -: 3]),
        .pp_o     (pp_d[gi])
      );
    end
  endgenerate

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      v2_q <= 1'b0;
      for (int i = 0; i < NPP; i++) begin
        pp_q[i] <= '0;
      end
    end else begin
      v2_q <= v2_d;
      if (rdy2 && v1_q) begin
        for (int i = 0; i < NPP; i++) begin
          pp_q[i] <= pp_d[i];
        end
      end
    end
  end

  // S3: reduction and final add; the exact product always fits in CW bits
  always_comb begin
    sum_d = '0;
    for (int i = 0; i < NPP; i++) begin
      sum_d = sum_d + pp_q[i];
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      v3_q <= 1'b0;
      c_q  <= '0;
    end else begin
      v3_q <= v3_d;
      if (rdy3 && v2_q) begin
        c_q <= sum_d[CW-1:0];
      end
    end
  end

endmodule
